// File: rtl/sys_pll_rst_mgr_pkg.sv
// Shared types and constants for the PLL supervisor / staged reset sequencer.
// The state encoding is fixed so o_state can be decoded directly by debug tools.
package sys_pll_rst_mgr_pkg;

  localparam int CNT_W   = 8;
  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4
  } state_e;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/sys_pll_rst_mgr_sync.sv
// N-flop synchroniser for the asynchronous PLL lock flag; resets to 0 so an
// unknown lock state always reads as "not locked".
module rst_mgr_sync #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_nrst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], i_d};
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign o_q = sync_q[STAGES-1];

endmodule

// File: rtl/sys_pll_rst_mgr.sv
// PLL supervisor and staged reset sequencer: qualifies lock, retries on timeout,
// releases NCH reset domains in order. Loss counter built only with SYS_PLL_RST_MGR_LOSS_CNT_EN.
module sys_pll_rst_mgr
  import sys_pll_rst_mgr_pkg::*;
#(
  parameter int NCH              = 4,
  parameter int SYNC_STAGES      = 2,
  parameter int PLL_RST_CYC      = 32,
  parameter int LOCK_TIMEOUT_CYC = 65536,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int STAGE_GAP_CYC    = 16
) (
  input  logic               i_clk,
  input  logic               i_nrst,
  input  logic               i_pll_locked,
  input  logic               i_sw_rst,
  output logic               o_pll_rst,
  output logic [NCH-1:0]     o_ch_nrst,
  output logic               o_ready,
  output logic [CNT_W-1:0]   o_lock_lost_cnt,
  output logic [STATE_W-1:0] o_state
);

  localparam int MAX_CYC = max4(PLL_RST_CYC, LOCK_TIMEOUT_CYC, LOCK_STABLE_CYC, STAGE_GAP_CYC);
  localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int IDX_W   = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(PLL_RST_CYC - 1);
  localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0] STB_LAST = TMR_W'(LOCK_STABLE_CYC - 1);
  localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(STAGE_GAP_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCH - 1);

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [IDX_W-1:0] idx_q, idx_d, idx_nxt;
  logic             pll_rst_q, pll_rst_d;
  logic             ready_q, ready_d;
  logic [NCH-1:0]   ch_nrst_q, ch_nrst_d;
  logic             lock_s;

  rst_mgr_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .i_clk  (i_clk),
    .i_nrst (i_nrst),
    .i_d    (i_pll_locked),
    .o_q    (lock_s)
  );

  // Lock loss outranks a software request in RELEASE/RUN so the event is counted.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + 1'b1;
    idx_d   = idx_q;
    idx_nxt = idx_q + 1'b1;
    case (state_q)
      ST_PLL_RST: begin
        if (i_sw_rst) begin
          timer_d = '0;
        end else if (timer_q == RST_LAST) begin
          state_d = ST_WAIT_LOCK;
          timer_d = '0;
        end
      end
      ST_WAIT_LOCK: begin
        if (i_sw_rst || (!lock_s && timer_q == TO_LAST)) begin
          state_d = ST_PLL_RST;
          timer_d = '0;
        end else if (lock_s) begin
          state_d = ST_STABLE;
          timer_d = '0;
        end
      end
      ST_STABLE: begin
        if (i_sw_rst) begin
          state_d = ST_PLL_RST;
          timer_d = '0;
        end else if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          timer_d = '0;
        end else if (timer_q == STB_LAST) begin
          state_d = (NCH == 1) ? ST_RUN : ST_RELEASE;
          timer_d = '0;
          idx_d   = '0;
        end
      end
      ST_RELEASE: begin
        if (!lock_s || i_sw_rst) begin
          state_d = ST_PLL_RST;
          timer_d = '0;
          idx_d   = '0;
        end else if (timer_q == GAP_LAST) begin
          timer_d = '0;
          idx_d   = idx_nxt;
          if (idx_nxt == IDX_LAST) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        timer_d = timer_q;
        if (!lock_s || i_sw_rst) begin
          state_d = ST_PLL_RST;
          timer_d = '0;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = ST_PLL_RST;
        timer_d = '0;
        idx_d   = '0;
      end
    endcase

    pll_rst_d = (state_d == ST_PLL_RST);
    ready_d   = (state_d == ST_RUN);
    ch_nrst_d = '0;
    for (int k = 0; k < NCH; k++) begin
      ch_nrst_d[k] = ((state_d == ST_RELEASE) || (state_d == ST_RUN)) && (k <= int'(idx_d));
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q   <= ST_PLL_RST;
      timer_q   <= '0;
      idx_q     <= '0;
      pll_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      ch_nrst_q <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      idx_q     <= idx_d;
      pll_rst_q <= pll_rst_d;
      ready_q   <= ready_d;
      ch_nrst_q <= ch_nrst_d;
    end
  end

`ifdef SYS_PLL_RST_MGR_LOSS_CNT_EN
  logic             loss;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign loss = ((state_q == ST_RELEASE) || (state_q == ST_RUN)) && !lock_s;

  always_comb begin
    cnt_d = cnt_q;
    if (loss && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_lock_lost_cnt = cnt_q;
`else
  assign o_lock_lost_cnt = '0;
`endif

  assign o_pll_rst = pll_rst_q;
  assign o_ch_nrst = ch_nrst_q;
  assign o_ready   = ready_q;
  assign o_state   = state_q;

endmodule

// File: tb/tb_sys_pll_rst_mgr.sv
// Directed bench for sys_pll_rst_mgr with hand-computed cycle-exact expectations.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_sys_pll_rst_mgr;

  localparam int NCH = 3;
  localparam logic [2:0] S_RST  = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_STB  = 3'd2;
  localparam logic [2:0] S_REL  = 3'd3;
  localparam logic [2:0] S_RUN  = 3'd4;
`ifdef SYS_PLL_RST_MGR_LOSS_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic locked = 1'b0;
  logic sw_rst = 1'b0;
  always #5 clk = ~clk;

  logic           o_pll_rst;
  logic [NCH-1:0] o_ch_nrst;
  logic           o_ready;
  logic [7:0]     o_lock_lost_cnt;
  logic [2:0]     o_state;

  int n_checks = 0;
  int n_errors = 0;
  int cnt_mdl  = 0;

  sys_pll_rst_mgr #(
    .NCH(NCH), .SYNC_STAGES(2), .PLL_RST_CYC(4), .LOCK_TIMEOUT_CYC(32),
    .LOCK_STABLE_CYC(8), .STAGE_GAP_CYC(4)
  ) dut (
    .i_clk           (clk),
    .i_nrst          (nrst),
    .i_pll_locked    (locked),
    .i_sw_rst        (sw_rst),
    .o_pll_rst       (o_pll_rst),
    .o_ch_nrst       (o_ch_nrst),
    .o_ready         (o_ready),
    .o_lock_lost_cnt (o_lock_lost_cnt),
    .o_state         (o_state)
  );

  // scoreboard
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [2:0] st, input logic pr,
                           input logic [2:0] ch, input logic rdy);
    logic [31:0] exp_cnt;
    exp_cnt = CNT_EN ? 32'(cnt_mdl) : 32'd0;
    check({tag, ".state"}, 32'(o_state), 32'(st));
    check({tag, ".pll_rst"}, 32'(o_pll_rst), 32'(pr));
    check({tag, ".ch_nrst"}, 32'(o_ch_nrst), 32'(ch));
    check({tag, ".ready"}, 32'(o_ready), 32'(rdy));
    check({tag, ".cnt"}, 32'(o_lock_lost_cnt), exp_cnt);
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset(input logic lock_val);
    nrst    = 1'b0;
    sw_rst  = 1'b0;
    locked  = lock_val;
    cnt_mdl = 0;
    #2;
    check_out("reset", S_RST, 1'b1, 3'b000, 1'b0);
    @(posedge clk);
    #1;
    nrst = 1'b1;
  endtask

  task automatic loss_event();
    if (cnt_mdl < 255) cnt_mdl++;
  endtask

  initial begin
    tick(2);

    // cold start, lock high throughout
    apply_reset(1'b1);
    tick(3); check_out("cold.e3",  S_RST,  1'b1, 3'b000, 1'b0);
    tick(1); check_out("cold.e4",  S_WAIT, 1'b0, 3'b000, 1'b0);
    tick(1); check_out("cold.e5",  S_STB,  1'b0, 3'b000, 1'b0);
    tick(7); check_out("cold.e12", S_STB,  1'b0, 3'b000, 1'b0);
    tick(1); check_out("cold.e13", S_REL,  1'b0, 3'b001, 1'b0);
    tick(3); check_out("cold.e16", S_REL,  1'b0, 3'b001, 1'b0);
    tick(1); check_out("cold.e17", S_REL,  1'b0, 3'b011, 1'b0);
    tick(3); check_out("cold.e20", S_REL,  1'b0, 3'b011, 1'b0);
    tick(1); check_out("cold.e21", S_RUN,  1'b0, 3'b111, 1'b1);
    tick(5); check_out("cold.e26", S_RUN,  1'b0, 3'b111, 1'b1);

    // lock never arrives: retry every 4 + 32 cycles (also an async reset from RUN)
    apply_reset(1'b0);
    tick(4);  check_out("tmo.e4",  S_WAIT, 1'b0, 3'b000, 1'b0);
    tick(31); check_out("tmo.e35", S_WAIT, 1'b0, 3'b000, 1'b0);
    tick(1);  check_out("tmo.e36", S_RST,  1'b1, 3'b000, 1'b0);
    tick(3);  check_out("tmo.e39", S_RST,  1'b1, 3'b000, 1'b0);
    tick(1);  check_out("tmo.e40", S_WAIT, 1'b0, 3'b000, 1'b0);
    tick(32); check_out("tmo.e72", S_RST,  1'b1, 3'b000, 1'b0);

    // glitchy lock: 5 high, 1 low, then high
    apply_reset(1'b0);
    tick(4); check_out("gl.e4", S_WAIT, 1'b0, 3'b000, 1'b0);
    locked = 1'b1;
    tick(3); check_out("gl.e7", S_STB, 1'b0, 3'b000, 1'b0);
    tick(2);
    locked = 1'b0;
    tick(1);
    locked = 1'b1;
    tick(1); check_out("gl.e11", S_STB,  1'b0, 3'b000, 1'b0);
    tick(1); check_out("gl.e12", S_WAIT, 1'b0, 3'b000, 1'b0);
    tick(1); check_out("gl.e13", S_STB,  1'b0, 3'b000, 1'b0);
    tick(7); check_out("gl.e20", S_STB,  1'b0, 3'b000, 1'b0);
    tick(1); check_out("gl.e21", S_REL,  1'b0, 3'b001, 1'b0);
    tick(8); check_out("gl.e29", S_RUN,  1'b0, 3'b111, 1'b1);

    // lock loss in RUN
    locked = 1'b0;
    tick(2); check_out("rloss.pre", S_RUN, 1'b0, 3'b111, 1'b1);
    tick(1); loss_event();
    check_out("rloss.hit", S_RST, 1'b1, 3'b000, 1'b0);
    locked = 1'b1;
    tick(4); check_out("rloss.wait", S_WAIT, 1'b0, 3'b000, 1'b0);
    tick(1); check_out("rloss.stb",  S_STB,  1'b0, 3'b000, 1'b0);
    tick(8); check_out("rloss.rel",  S_REL,  1'b0, 3'b001, 1'b0);
    tick(8); check_out("rloss.run",  S_RUN,  1'b0, 3'b111, 1'b1);

    // one-cycle software reset in RUN
    sw_rst = 1'b1;
    tick(1);
    sw_rst = 1'b0;
    check_out("sw.hit", S_RST, 1'b1, 3'b000, 1'b0);
    tick(4);  check_out("sw.wait", S_WAIT, 1'b0, 3'b000, 1'b0);
    tick(1);  check_out("sw.stb",  S_STB,  1'b0, 3'b000, 1'b0);
    tick(16); check_out("sw.run",  S_RUN,  1'b0, 3'b111, 1'b1);

    // software reset held in PLL_RST restarts the hold count
    sw_rst = 1'b1;
    tick(3); check_out("swh.e3", S_RST, 1'b1, 3'b000, 1'b0);
    sw_rst = 1'b0;
    tick(3);  check_out("swh.e6",  S_RST,  1'b1, 3'b000, 1'b0);
    tick(1);  check_out("swh.e7",  S_WAIT, 1'b0, 3'b000, 1'b0);
    tick(1);  check_out("swh.e8",  S_STB,  1'b0, 3'b000, 1'b0);
    tick(16); check_out("swh.e24", S_RUN,  1'b0, 3'b111, 1'b1);

    // lock loss and software reset on the same edge
    locked = 1'b0;
    tick(2);
    sw_rst = 1'b1;
    check_out("both.pre", S_RUN, 1'b0, 3'b111, 1'b1);
    tick(1);
    sw_rst = 1'b0;
    loss_event();
    check_out("both.hit", S_RST, 1'b1, 3'b000, 1'b0);
    locked = 1'b1;

    // repeated loss after channel 0 release drives the counter to saturation
    for (int i = 0; i < 300; i++) begin
      tick(13); check_out("sat.rel", S_REL, 1'b0, 3'b001, 1'b0);
      locked = 1'b0;
      tick(3); loss_event();
      check_out("sat.loss", S_RST, 1'b1, 3'b000, 1'b0);
      locked = 1'b1;
    end
    check("sat.final", 32'(o_lock_lost_cnt), CNT_EN ? 32'd255 : 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
